rr_bus_arbiter4: RTL and testbench



---
 rtl/rr_bus_arbiter4_pkg.sv | 16 +
 rtl/rr_bus_arbiter4_if.sv | 32 +++
 rtl/rr_bus_arbiter4_mux4to1.sv | 24 ++
 rtl/rr_bus_arbiter4.sv | 104 ++++++++++
 tb/tb_rr_bus_arbiter4.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rr_bus_arbiter4_pkg.sv
// Shared types and constants for the four-way round-robin bus arbiter.
package rr_bus_arbiter4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_FWD = 2;
  localparam int REQ_IO  = 3;

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/rr_bus_arbiter4_if.sv
// Requester/consumer bus bundle seen by the arbiter; the slave side is the arbiter itself.
interface rr_bus_arbiter4_if
  import rr_bus_arbiter4_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [3:0]        req;
  logic [3:0]        last;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [DATA_W-1:0] d3;
  logic              out_ready;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              busy;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output req, last, d0, d1, d2, d3, out_ready,
    input  gnt, sel, busy, out_valid, out_data, out_last
  );

  modport slave (
    input  req, last, d0, d1, d2, d3, out_ready,
    output gnt, sel, busy, out_valid, out_data, out_last
  );

endinterface

// File: rtl/rr_bus_arbiter4_mux4to1.sv
// Byte-lane 4:1 mux shared by the write-back/bus stage.
module mux4to1 #(
  parameter int W = 8
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// Round-robin arbiter for four requesters sharing one bus path, with
// last-terminated bursts capped at MAX_BURST beats and a valid/ready consumer.
module rr_bus_arbiter4
  import rr_bus_arbiter4_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_bus_arbiter4_if.slave   bus
);

  state_t           state;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             busy;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic             out_valid;
  logic             out_last;
  logic             xfer;
  logic [1:0]       winner;

  // First set request bit scanning upward from the pointer, wrapping at 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    idx     = p;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner    = rr_pick(bus.req, ptr);
  assign out_valid = busy & bus.req[sel];
  assign out_last  = busy & (bus.last[sel] | (cnt == CNT_W'(MAX_BURST - 1)));
  assign xfer      = out_valid & bus.out_ready;

  assign bus.gnt       = gnt;
  assign bus.sel       = sel;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;

  mux4to1 #(.W(DATA_W)) u_mux (
    .sel (sel),
    .d0  (bus.d0),
    .d1  (bus.d1),
    .d2  (bus.d2),
    .d3  (bus.d3),
    .y   (bus.out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      busy  <= 1'b0;
      ptr   <= 2'd0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req != 4'b0000) begin
            sel   <= winner;
            gnt   <= 4'b0001 << winner;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          // An abandoned request releases even if the consumer is stalled.
          if (!bus.req[sel] || (xfer && out_last)) begin
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            cnt   <= '0;
            ptr   <= sel + 2'd1;
            state <= IDLE;
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Table-driven scoreboard bench for rr_bus_arbiter4 (MAX_BURST=4).
module tb_rr_bus_arbiter4;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] dat;
    logic        rdy;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        busy;
    logic        valid;
    logic [7:0]  data;
    logic        olast;
    logic [1:0]  ptr;
    logic [1:0]  cnt;
  } vec_t;

  logic clk;
  logic rst_n;

  rr_bus_arbiter4_if #(.DATA_W(8)) bus();

  rr_bus_arbiter4 #(.DATA_W(8), .MAX_BURST(4), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   vectors = 0;
  int   miscompares = 0;
  vec_t vecs[$];
  vec_t expq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] last,
                              input logic [31:0] dat, input logic rdy,
                              input logic [3:0] gnt, input logic [1:0] sel,
                              input logic busy, input logic valid,
                              input logic [7:0] data, input logic olast,
                              input logic [1:0] ptr, input logic [1:0] cnt);
    vec_t v;
    v.req = req; v.last = last; v.dat = dat; v.rdy = rdy;
    v.gnt = gnt; v.sel = sel; v.busy = busy; v.valid = valid;
    v.data = data; v.olast = olast; v.ptr = ptr; v.cnt = cnt;
    return v;
  endfunction

  task automatic cmp(input int id, input string name, input logic [7:0] got, input logic [7:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL vec%0d %s: got %0h, required %0h", id, name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    bus.req       = v.req;
    bus.last      = v.last;
    bus.d0        = v.dat[7:0];
    bus.d1        = v.dat[15:8];
    bus.d2        = v.dat[23:16];
    bus.d3        = v.dat[31:24];
    bus.out_ready = v.rdy;
    expq.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (expq.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard: got empty queue, required an entry");
      return;
    end
    e = expq.pop_front();
    cmp(vectors, "gnt",       8'(bus.gnt),       8'(e.gnt));
    cmp(vectors, "sel",       8'(bus.sel),       8'(e.sel));
    cmp(vectors, "busy",      8'(bus.busy),      8'(e.busy));
    cmp(vectors, "out_valid", 8'(bus.out_valid), 8'(e.valid));
    cmp(vectors, "out_last",  8'(bus.out_last),  8'(e.olast));
    cmp(vectors, "ptr",       8'(dut.ptr),       8'(e.ptr));
    cmp(vectors, "cnt",       8'(dut.cnt),       8'(e.cnt));
    if (e.valid) cmp(vectors, "out_data", bus.out_data, e.data);
    vectors++;
  endtask

  localparam logic [31:0] D = 32'h44_33_22_11;

  initial begin
    // rotation, starting from ptr=0
    vecs.push_back(mk(4'hF, 4'hF, D, 1, 4'h0, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(4'hF, 4'hF, D, 1, 4'h1, 0, 1, 1, 8'h11, 1, 0, 0));
    vecs.push_back(mk(4'hF, 4'hF, D, 1, 4'h0, 0, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(4'hF, 4'hF, D, 1, 4'h2, 1, 1, 1, 8'h22, 1, 1, 0));
    vecs.push_back(mk(4'hF, 4'hF, D, 1, 4'h0, 1, 0, 0, 8'h00, 0, 2, 0));
    vecs.push_back(mk(4'hF, 4'hF, D, 1, 4'h4, 2, 1, 1, 8'h33, 1, 2, 0));
    vecs.push_back(mk(4'hF, 4'hF, D, 1, 4'h0, 2, 0, 0, 8'h00, 0, 3, 0));
    vecs.push_back(mk(4'hF, 4'hF, D, 1, 4'h8, 3, 1, 1, 8'h44, 1, 3, 0));
    vecs.push_back(mk(4'hF, 4'hF, D, 1, 4'h0, 3, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(4'hF, 4'hF, D, 1, 4'h1, 0, 1, 1, 8'h11, 1, 0, 0));
    vecs.push_back(mk(4'h0, 4'h0, D, 1, 4'h0, 0, 0, 0, 8'h00, 0, 1, 0));
    // single request on requester 2
    vecs.push_back(mk(4'h4, 4'h4, 32'h44_A5_22_11, 1, 4'h0, 0, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(4'h4, 4'h4, 32'h44_A5_22_11, 1, 4'h4, 2, 1, 1, 8'hA5, 1, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 32'h44_A5_22_11, 1, 4'h0, 2, 0, 0, 8'h00, 0, 3, 0));
    // burst cap on requester 1
    vecs.push_back(mk(4'h2, 4'h0, 32'h44_33_10_11, 1, 4'h0, 2, 0, 0, 8'h00, 0, 3, 0));
    vecs.push_back(mk(4'h2, 4'h0, 32'h44_33_10_11, 1, 4'h2, 1, 1, 1, 8'h10, 0, 3, 0));
    vecs.push_back(mk(4'h2, 4'h0, 32'h44_33_11_11, 1, 4'h2, 1, 1, 1, 8'h11, 0, 3, 1));
    vecs.push_back(mk(4'h2, 4'h0, 32'h44_33_12_11, 1, 4'h2, 1, 1, 1, 8'h12, 0, 3, 2));
    vecs.push_back(mk(4'h2, 4'h0, 32'h44_33_13_11, 1, 4'h2, 1, 1, 1, 8'h13, 1, 3, 3));
    vecs.push_back(mk(4'h0, 4'h0, 32'h44_33_13_11, 1, 4'h0, 1, 0, 0, 8'h00, 0, 2, 0));
    // backpressure on requester 3, then one beat, then abandon
    vecs.push_back(mk(4'h8, 4'h0, 32'h77_33_22_11, 0, 4'h0, 1, 0, 0, 8'h00, 0, 2, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'h8, 4'h0, 32'h77_33_22_11, 0, 4'h8, 3, 1, 1, 8'h77, 0, 2, 0));
    vecs.push_back(mk(4'h8, 4'h0, 32'h77_33_22_11, 1, 4'h8, 3, 1, 1, 8'h77, 0, 2, 0));
    vecs.push_back(mk(4'h8, 4'h0, 32'h77_33_22_11, 0, 4'h8, 3, 1, 1, 8'h77, 0, 2, 1));
    vecs.push_back(mk(4'h0, 4'h0, 32'h77_33_22_11, 0, 4'h8, 3, 1, 0, 8'h00, 0, 2, 1));
    vecs.push_back(mk(4'h0, 4'h0, 32'h77_33_22_11, 1, 4'h0, 3, 0, 0, 8'h00, 0, 0, 0));
    // abandon requester 0 after two beats while the consumer stalls
    vecs.push_back(mk(4'h1, 4'h0, 32'h44_33_22_C0, 1, 4'h0, 3, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h0, 32'h44_33_22_C0, 1, 4'h1, 0, 1, 1, 8'hC0, 0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h0, 32'h44_33_22_C0, 1, 4'h1, 0, 1, 1, 8'hC0, 0, 0, 1));
    vecs.push_back(mk(4'h0, 4'h0, 32'h44_33_22_C0, 0, 4'h1, 0, 1, 0, 8'h00, 0, 0, 2));
    vecs.push_back(mk(4'h0, 4'h0, 32'h44_33_22_C0, 1, 4'h0, 0, 0, 0, 8'h00, 0, 1, 0));
    // fairness: requesters 0 and 2 alternate
    vecs.push_back(mk(4'h5, 4'h5, D, 1, 4'h0, 0, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(4'h5, 4'h5, D, 1, 4'h4, 2, 1, 1, 8'h33, 1, 1, 0));
    vecs.push_back(mk(4'h5, 4'h5, D, 1, 4'h0, 2, 0, 0, 8'h00, 0, 3, 0));
    vecs.push_back(mk(4'h5, 4'h5, D, 1, 4'h1, 0, 1, 1, 8'h11, 1, 3, 0));
    vecs.push_back(mk(4'h0, 4'h0, D, 1, 4'h0, 0, 0, 0, 8'h00, 0, 1, 0));

    rst_n = 1'b0;
    bus.req = 4'h0; bus.last = 4'h0; bus.out_ready = 1'b0;
    bus.d0 = 8'h00; bus.d1 = 8'h00; bus.d2 = 8'h00; bus.d3 = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    expq.push_back(mk(4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0, 0));
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput();
    end

    // asynchronous reset in the middle of a burst on requester 2
    applyStimulus(mk(4'h4, 4'h0, D, 1, 4'h0, 0, 0, 0, 8'h00, 0, 1, 0));
    @(negedge clk);
    checkOutput();
    applyStimulus(mk(4'h4, 4'h0, D, 1, 4'h4, 2, 1, 1, 8'h33, 0, 1, 0));
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    expq.push_back(mk(4'h4, 4'h0, D, 1, 4'h0, 0, 0, 0, 8'h00, 0, 0, 0));
    checkOutput();
    bus.req = 4'h0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // ptr back at 0: requester 0 beats requester 3
    applyStimulus(mk(4'h9, 4'h9, D, 1, 4'h0, 0, 0, 0, 8'h00, 0, 0, 0));
    @(negedge clk);
    checkOutput();
    applyStimulus(mk(4'h9, 4'h9, D, 1, 4'h1, 0, 1, 1, 8'h11, 1, 0, 0));
    @(negedge clk);
    checkOutput();
    applyStimulus(mk(4'h0, 4'h0, D, 1, 4'h0, 0, 0, 0, 8'h00, 0, 1, 0));
    @(negedge clk);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
